// File: rtl/lifm_column_gen_if.sv
// ---------------------------------------------------------------------------
// lifm_column_gen_if
// Bundles the two bus-like port groups of lifm_column_gen:
//   * IFM memory read port : mem_rd_en, mem_addr (driven by the generator),
//                            mem_rdata (returned one cycle after mem_rd_en)
//   * LIFM vector stream   : out_valid, kidx, lifm_column, last_kidx,
//                            last_window (driven by the generator),
//                            out_ready (driven by the consumer)
// master : the column generator
// slave  : memory + downstream consumer
// ---------------------------------------------------------------------------
interface lifm_column_gen_if #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int STEP_RANGE = 128
);
  logic                             mem_rd_en;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic [WORD_WIDTH-1:0]            mem_rdata;
  logic                             out_valid;
  logic                             out_ready;
  logic [WORD_WIDTH-1:0]            kidx;
  logic [WORD_WIDTH*STEP_RANGE-1:0] lifm_column;
  logic                             last_kidx;
  logic                             last_window;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rdata,
    output out_valid, kidx, lifm_column, last_kidx, last_window,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rdata,
    input  out_valid, kidx, lifm_column, last_kidx, last_window,
    output out_ready
  );
endinterface

// File: rtl/lifm_column_gen.sv
// ---------------------------------------------------------------------------
// lifm_column_gen
// Lowers a single-channel IFM into LIFM row vectors. For every window of
// STEP_RANGE consecutive output positions and every kernel element
// kidx = ky*FW+kx, one vector is built lane by lane from a word-wide
// synchronous memory and handed downstream together with its kidx.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : start pulse, only looked at while idle
//   ifm_width (W), ke_width (FW), ke_height (FH), of_width (OW),
//   of_height (OH), stride (S) : geometry, latched on the start cycle
//   busy              : high whenever not idle
//   done              : one-cycle pulse after the final vector is accepted
//   bus (master)      : memory read port and vector stream
// ---------------------------------------------------------------------------
module lifm_column_gen #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int STEP_RANGE = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] ifm_width,
  input  logic [WORD_WIDTH-1:0] ke_width,
  input  logic [WORD_WIDTH-1:0] ke_height,
  input  logic [WORD_WIDTH-1:0] of_width,
  input  logic [WORD_WIDTH-1:0] of_height,
  input  logic [WORD_WIDTH-1:0] stride,
  output logic                  busy,
  output logic                  done,
  lifm_column_gen_if.master     bus
);

  localparam int LANE_W = (STEP_RANGE > 1) ? $clog2(STEP_RANGE) : 1;
  localparam int PROD_W = 2 * WORD_WIDTH;
  // Window base may run up to STEP_RANGE past OH*OW before the last-window test.
  localparam int POS_W  = PROD_W + LANE_W + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_OUTPUT = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]            state_reg;
  logic [WORD_WIDTH-1:0] cfg_w_reg, cfg_fw_reg, cfg_fh_reg;
  logic [WORD_WIDTH-1:0] cfg_ow_reg, cfg_oh_reg, cfg_s_reg;
  logic [PROD_W-1:0]     total_pos_reg;
  logic [POS_W-1:0]      win_base_reg;
  logic [WORD_WIDTH-1:0] win_ox_reg, win_oy_reg;
  logic [WORD_WIDTH-1:0] ox_reg, oy_reg;
  logic [WORD_WIDTH-1:0] kx_reg, ky_reg, kidx_reg;
  logic [LANE_W-1:0]     lane_reg;
  // Capture pipeline: the lane fetched in cycle n is written in cycle n+1.
  logic                  cap_en_reg;
  logic                  cap_rd_reg;
  logic [LANE_W-1:0]     cap_lane_reg;

  logic [POS_W-1:0]      lane_pos_c;
  logic                  lane_valid_c;
  logic                  rd_fire_c;
  logic                  last_k_c;
  logic                  last_win_c;
  logic                  cfg_zero_c;
  logic [ADDR_WIDTH-1:0] row_c, col_c, addr_c;

  assign lane_pos_c   = win_base_reg + POS_W'(lane_reg);
  assign lane_valid_c = lane_pos_c < POS_W'(total_pos_reg);
  assign rd_fire_c    = (state_reg == ST_FETCH) && lane_valid_c;
  assign last_k_c     = (kx_reg == cfg_fw_reg - WORD_WIDTH'(1)) &&
                        (ky_reg == cfg_fh_reg - WORD_WIDTH'(1));
  assign last_win_c   = (win_base_reg + POS_W'(STEP_RANGE)) >= POS_W'(total_pos_reg);
  assign cfg_zero_c   = (cfg_w_reg == '0) || (cfg_fw_reg == '0) || (cfg_fh_reg == '0) ||
                        (cfg_ow_reg == '0) || (cfg_oh_reg == '0) || (cfg_s_reg == '0);

  // Address is only meaningful modulo 2^ADDR_WIDTH, so the whole expression
  // is evaluated at that width.
  assign row_c  = ADDR_WIDTH'(oy_reg) * ADDR_WIDTH'(cfg_s_reg) + ADDR_WIDTH'(ky_reg);
  assign col_c  = ADDR_WIDTH'(ox_reg) * ADDR_WIDTH'(cfg_s_reg) + ADDR_WIDTH'(kx_reg);
  assign addr_c = row_c * ADDR_WIDTH'(cfg_w_reg) + col_c;

  assign bus.mem_rd_en   = rd_fire_c;
  assign bus.mem_addr    = rd_fire_c ? addr_c : '0;
  assign bus.out_valid   = (state_reg == ST_OUTPUT);
  assign bus.kidx        = kidx_reg;
  assign bus.last_kidx   = (state_reg == ST_OUTPUT) && last_k_c;
  assign bus.last_window = (state_reg == ST_OUTPUT) && last_win_c;
  assign busy            = (state_reg != ST_IDLE);
  assign done            = (state_reg == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cfg_w_reg     <= '0;
      cfg_fw_reg    <= '0;
      cfg_fh_reg    <= '0;
      cfg_ow_reg    <= '0;
      cfg_oh_reg    <= '0;
      cfg_s_reg     <= '0;
      total_pos_reg <= '0;
      win_base_reg  <= '0;
      win_ox_reg    <= '0;
      win_oy_reg    <= '0;
      ox_reg        <= '0;
      oy_reg        <= '0;
      kx_reg        <= '0;
      ky_reg        <= '0;
      kidx_reg      <= '0;
      lane_reg      <= '0;
      cap_en_reg    <= 1'b0;
      cap_rd_reg    <= 1'b0;
      cap_lane_reg  <= '0;
    end else begin
      cap_en_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cfg_w_reg  <= ifm_width;
            cfg_fw_reg <= ke_width;
            cfg_fh_reg <= ke_height;
            cfg_ow_reg <= of_width;
            cfg_oh_reg <= of_height;
            cfg_s_reg  <= stride;
            state_reg  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          total_pos_reg <= PROD_W'(cfg_oh_reg) * PROD_W'(cfg_ow_reg);
          win_base_reg  <= '0;
          win_ox_reg    <= '0;
          win_oy_reg    <= '0;
          ox_reg        <= '0;
          oy_reg        <= '0;
          kx_reg        <= '0;
          ky_reg        <= '0;
          kidx_reg      <= '0;
          lane_reg      <= '0;
          state_reg     <= cfg_zero_c ? ST_DONE : ST_FETCH;
        end

        ST_FETCH: begin
          cap_en_reg   <= 1'b1;
          cap_rd_reg   <= lane_valid_c;
          cap_lane_reg <= lane_reg;
          // Position walks on even through invalid tail lanes; nothing reads it.
          if (ox_reg == cfg_ow_reg - WORD_WIDTH'(1)) begin
            ox_reg <= '0;
            oy_reg <= oy_reg + WORD_WIDTH'(1);
          end else begin
            ox_reg <= ox_reg + WORD_WIDTH'(1);
          end
          if (lane_reg == LANE_W'(STEP_RANGE - 1)) begin
            lane_reg  <= '0;
            state_reg <= ST_DRAIN;
          end else begin
            lane_reg <= lane_reg + LANE_W'(1);
          end
        end

        ST_DRAIN: begin
          state_reg <= ST_OUTPUT;
        end

        ST_OUTPUT: begin
          if (bus.out_ready) begin
            lane_reg <= '0;
            if (last_k_c) begin
              if (last_win_c) begin
                state_reg <= ST_DONE;
              end else begin
                // After STEP_RANGE steps ox/oy already sit on the next window's
                // first position, so they become the new saved start.
                win_base_reg <= win_base_reg + POS_W'(STEP_RANGE);
                win_ox_reg   <= ox_reg;
                win_oy_reg   <= oy_reg;
                kx_reg       <= '0;
                ky_reg       <= '0;
                kidx_reg     <= '0;
                state_reg    <= ST_FETCH;
              end
            end else begin
              if (kx_reg == cfg_fw_reg - WORD_WIDTH'(1)) begin
                kx_reg <= '0;
                ky_reg <= ky_reg + WORD_WIDTH'(1);
              end else begin
                kx_reg <= kx_reg + WORD_WIDTH'(1);
              end
              kidx_reg  <= kidx_reg + WORD_WIDTH'(1);
              ox_reg    <= win_ox_reg;
              oy_reg    <= win_oy_reg;
              state_reg <= ST_FETCH;
            end
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Lane storage: each lane is written once per vector, zero for lanes past
  // the end of the output map (no read was issued for those).
  genvar gi;
  generate
    for (gi = 0; gi < STEP_RANGE; gi++) begin : g_lane
      logic [WORD_WIDTH-1:0] data_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_reg <= '0;
        end else if (cap_en_reg && (cap_lane_reg == LANE_W'(gi))) begin
          data_reg <= cap_rd_reg ? bus.mem_rdata : '0;
        end
      end

      assign bus.lifm_column[gi*WORD_WIDTH +: WORD_WIDTH] = data_reg;
    end
  endgenerate

endmodule
